// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and constants for the debouncer.
//   state_t      - debouncer FSM state encoding (2 bits)
//   GLITCH_CNT_W - width of the optional glitch counter output
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam int GLITCH_CNT_W = 8;

endpackage

// File: rtl/debounce_sync_chain.sv
// sync_chain: multi-flop synchronizer for a single asynchronous bit.
// Reusable for any asynchronous input; output is the last flop of the chain.
//   clk  - sampling clock
//   rst  - synchronous active-high reset, clears the chain to 0
//   in   - asynchronous input
//   out  - synchronized level, SYNC_STAGES cycles behind in
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], in};
  end

  assign out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/debounce.sv
// debounce: turns a raw, bouncy asynchronous input into a clean synchronous
// level. The input is synchronized, then an FSM requires the synchronized
// level to differ from out for DEBOUNCE_CYCLES consecutive cycles before out
// follows it. Any bounce during qualification abandons the candidate.
//   clk        - system clock
//   rst        - synchronous active-high reset
//   in         - raw asynchronous input
//   out        - debounced level (registered)
//   busy       - high while a candidate transition is being qualified
//   glitch_cnt - saturating count of abandoned candidates; present only
//                when DEBOUNCE_GLITCH_CNT_EN is defined
module debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (s)
  );

  // cnt counts cycles the candidate level has been seen, so entering a WAIT
  // state loads 1 and qualification fires when cnt reaches DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE_LO;
      cnt   <= '0;
      out   <= 1'b0;
      busy  <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      glitch_cnt <= '0;
`endif
    end else begin
      case (state)
        STABLE_LO: begin
          if (s) begin
            state <= WAIT_HI;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end else begin
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state <= STABLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if (glitch_cnt != '1) glitch_cnt <= glitch_cnt + 1'b1;
`endif
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HI;
            out   <= 1'b1;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt   <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state <= WAIT_LO;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end else begin
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        WAIT_LO: begin
          if (s) begin
            state <= STABLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if (glitch_cnt != '1) glitch_cnt <= glitch_cnt + 1'b1;
`endif
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LO;
            out   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt   <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
          out   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
